// File: rtl/vend_controller.sv
// vend_controller: sequencing FSM for the drink vending machine.
// Tracks inserted credit against per-drink prices and stock sensors, drives
// the 7-segment display block (select/soma/bebida/flags), and pulses the
// dispense and refund strobes to the mechanism. All outputs are registered.
// Optional feature: define VEND_TIMEOUT_EN to auto-cancel after
// TIMEOUT_CYCLES of inactivity in CREDIT.
module vend_controller #(
  parameter logic [4:0]  PRICE1         = 5'd3,
  parameter logic [4:0]  PRICE2         = 5'd5,
  parameter logic [4:0]  PRICE3         = 5'd7,
  parameter logic [31:0] MSG_CYCLES     = 32'd50_000_000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel_strobe,
  input  logic [1:0] sel_drink,
  input  logic       note_strobe,
  input  logic [2:0] note_code,
  input  logic       cancel,
  input  logic [2:0] sensores,
  output logic [2:0] select,
  output logic [4:0] soma,
  output logic [1:0] bebida,
  output logic       cedulaINV,
  output logic       valoramais,
  output logic       dispense,
  output logic       refund,
  output logic [4:0] refund_value
);

  typedef enum logic [2:0] {
    S_IDLE, S_CREDIT, S_DISPENSE, S_CHANGE, S_MSG
  } state_t;

  state_t      state;
  state_t      ret_state;
  logic [4:0]  credit;
  logic [31:0] msg_timer;
  logic [5:0]  credit_sum;
  logic [4:0]  price_cur;
  logic        timeout_hit;
  logic        cancel_now;
  logic        msg_done;

  // Banknote code to currency value; invalid codes map to 0.
  function automatic logic [4:0] note_value(input logic [2:0] code);
    case (code)
      3'd1:    note_value = 5'd1;
      3'd2:    note_value = 5'd2;
      3'd3:    note_value = 5'd5;
      3'd4:    note_value = 5'd10;
      default: note_value = 5'd0;
    endcase
  endfunction

  function automatic logic note_valid(input logic [2:0] code);
    note_valid = (code >= 3'd1) && (code <= 3'd4);
  endfunction

  function automatic logic [4:0] price_of(input logic [1:0] d);
    case (d)
      2'd1:    price_of = PRICE1;
      2'd2:    price_of = PRICE2;
      2'd3:    price_of = PRICE3;
      default: price_of = 5'd0;
    endcase
  endfunction

  // One extra bit so an over-limit note is detected instead of wrapping.
  assign credit_sum = {1'b0, credit} + {1'b0, note_value(note_code)};
  assign price_cur  = price_of(bebida);
  assign msg_done   = (msg_timer == MSG_CYCLES - 32'd1);
  // A timeout behaves as a cancel but never outranks a real note.
  assign cancel_now = cancel || (!note_strobe && timeout_hit);

`ifdef VEND_TIMEOUT_EN
  logic [31:0] idle_cnt;
  assign timeout_hit = (state == S_CREDIT) && (idle_cnt == TIMEOUT_CYCLES - 32'd1);

  // Inactivity counter: runs only in CREDIT, restarts on any note or cancel.
  always_ff @(posedge clk) begin
    if (reset || state != S_CREDIT || cancel || note_strobe || timeout_hit)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 32'd1;
  end
`else
  // Without the timeout option CREDIT waits indefinitely; TIMEOUT_CYCLES is inert.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

  // Main controller FSM with registered display and strobe outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ret_state    <= S_IDLE;
      credit       <= '0;
      msg_timer    <= '0;
      select       <= '0;
      soma         <= '0;
      bebida       <= '0;
      cedulaINV    <= 1'b0;
      valoramais   <= 1'b0;
      dispense     <= 1'b0;
      refund       <= 1'b0;
      refund_value <= '0;
    end else begin
      dispense     <= 1'b0;
      refund       <= 1'b0;
      refund_value <= '0;
      unique case (state)
        S_IDLE: begin
          if (!cancel && note_strobe) begin
            state     <= S_MSG;
            ret_state <= S_IDLE;
            msg_timer <= '0;
            select    <= 3'd6;
            cedulaINV <= 1'b1;
          end else if (!cancel && sel_strobe && sel_drink != 2'd0) begin
            if (sensores[sel_drink - 2'd1]) begin
              state     <= S_MSG;
              ret_state <= S_IDLE;
              msg_timer <= '0;
              select    <= 3'd5;
            end else begin
              state  <= S_CREDIT;
              bebida <= sel_drink;
              credit <= '0;
              soma   <= '0;
              select <= 3'd2;
            end
          end
        end
        S_CREDIT: begin
          if (cancel_now) begin
            refund       <= (credit != 5'd0);
            refund_value <= credit;
            credit       <= '0;
            bebida       <= '0;
            soma         <= '0;
            select       <= 3'd7;
            state        <= S_MSG;
            ret_state    <= S_IDLE;
            msg_timer    <= '0;
          end else if (note_strobe) begin
            if (note_valid(note_code) && credit_sum <= 6'd31) begin
              credit <= credit_sum[4:0];
              soma   <= credit_sum[4:0];
              if (credit_sum[4:0] >= price_cur) begin
                state  <= S_DISPENSE;
                select <= 3'd3;
              end
            end else begin
              state     <= S_MSG;
              ret_state <= S_CREDIT;
              msg_timer <= '0;
              select    <= 3'd6;
              cedulaINV <= 1'b1;
            end
          end
        end
        S_DISPENSE: begin
          dispense  <= 1'b1;
          msg_timer <= '0;
          if (credit > price_cur) begin
            refund       <= 1'b1;
            refund_value <= credit - price_cur;
            valoramais   <= 1'b1;
            soma         <= credit - price_cur;
            select       <= 3'd4;
            state        <= S_CHANGE;
          end else begin
            select    <= 3'd3;
            state     <= S_MSG;
            ret_state <= S_IDLE;
          end
        end
        S_CHANGE, S_MSG: begin
          if (!msg_done) begin
            msg_timer <= msg_timer + 32'd1;
          end else begin
            msg_timer  <= '0;
            cedulaINV  <= 1'b0;
            valoramais <= 1'b0;
            if (state == S_MSG && ret_state == S_CREDIT) begin
              state  <= S_CREDIT;
              select <= 3'd2;
              soma   <= credit;
            end else begin
              state  <= S_IDLE;
              select <= '0;
              soma   <= '0;
              bebida <= '0;
              credit <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed testbench for vend_controller (MSG_CYCLES=4, TIMEOUT_CYCLES=20).
// A second instance with PRICE3=31 covers the credit-limit boundary.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       reset, sel_strobe, note_strobe, cancel;
  logic [1:0] sel_drink;
  logic [2:0] note_code, sensores;

  logic [2:0] select;
  logic [4:0] soma, refund_value;
  logic [1:0] bebida;
  logic       cedulaINV, valoramais, dispense, refund;

  logic [2:0] b_select;
  logic [4:0] b_soma, b_refund_value;
  logic [1:0] b_bebida;
  logic       b_cedulaINV, b_valoramais, b_dispense, b_refund;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vend_controller #(.MSG_CYCLES(32'd4), .TIMEOUT_CYCLES(32'd20)) u_dut (
    .clk(clk), .reset(reset), .sel_strobe(sel_strobe), .sel_drink(sel_drink),
    .note_strobe(note_strobe), .note_code(note_code), .cancel(cancel), .sensores(sensores),
    .select(select), .soma(soma), .bebida(bebida), .cedulaINV(cedulaINV),
    .valoramais(valoramais), .dispense(dispense), .refund(refund), .refund_value(refund_value)
  );

  vend_controller #(.PRICE3(5'd31), .MSG_CYCLES(32'd4), .TIMEOUT_CYCLES(32'd20)) u_big (
    .clk(clk), .reset(reset), .sel_strobe(sel_strobe), .sel_drink(sel_drink),
    .note_strobe(note_strobe), .note_code(note_code), .cancel(cancel), .sensores(sensores),
    .select(b_select), .soma(b_soma), .bebida(b_bebida), .cedulaINV(b_cedulaINV),
    .valoramais(b_valoramais), .dispense(b_dispense), .refund(b_refund), .refund_value(b_refund_value)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sel_strobe = 1'b0; note_strobe = 1'b0; cancel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_sel(input logic [1:0] d);
    @(negedge clk); sel_drink = d; sel_strobe = 1'b1;
    @(negedge clk); sel_strobe = 1'b0;
  endtask

  task automatic pulse_note(input logic [2:0] c);
    @(negedge clk); note_code = c; note_strobe = 1'b1;
    @(negedge clk); note_strobe = 1'b0;
  endtask

  task automatic pulse_cancel();
    @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if ({select, soma, bebida, cedulaINV, valoramais, dispense, refund, refund_value} !== 20'd0) begin miscompares++; $display("FAIL reset_outputs got sel=%0d soma=%0d beb=%0d inv=%0b vm=%0b disp=%0b ref=%0b rv=%0d required all 0", select, soma, bebida, cedulaINV, valoramais, dispense, refund, refund_value); end
  endtask

  task automatic test_purchase_change();
    do_reset();
    pulse_sel(2'd2);
    vectors++; if ({select, bebida} !== {3'd2, 2'd2}) begin miscompares++; $display("FAIL buy_select sel=%0d beb=%0d required 2/2", select, bebida); end
    pulse_note(3'd2);
    vectors++; if (soma !== 5'd2) begin miscompares++; $display("FAIL buy_note1 soma=%0d required 2", soma); end
    pulse_note(3'd3);
    vectors++; if ({select, soma, dispense} !== {3'd3, 5'd7, 1'b0}) begin miscompares++; $display("FAIL buy_reach sel=%0d soma=%0d disp=%0b required 3/7/0", select, soma, dispense); end
    @(negedge clk);
    vectors++; if ({dispense, refund, refund_value, valoramais, select, soma} !== {1'b1, 1'b1, 5'd2, 1'b1, 3'd4, 5'd2}) begin miscompares++; $display("FAIL buy_change disp=%0b ref=%0b rv=%0d vm=%0b sel=%0d soma=%0d required 1/1/2/1/4/2", dispense, refund, refund_value, valoramais, select, soma); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if ({select, valoramais, dispense, refund} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin miscompares++; $display("FAIL buy_hold%0d sel=%0d vm=%0b disp=%0b ref=%0b required 4/1/0/0", i, select, valoramais, dispense, refund); end
    end
    @(negedge clk);
    vectors++; if ({select, soma, bebida, valoramais} !== {3'd0, 5'd0, 2'd0, 1'b0}) begin miscompares++; $display("FAIL buy_idle sel=%0d soma=%0d beb=%0d vm=%0b required 0/0/0/0", select, soma, bebida, valoramais); end
  endtask

  task automatic test_exact_price();
    pulse_sel(2'd1);
    pulse_note(3'd1);
    pulse_note(3'd2);
    vectors++; if ({select, soma} !== {3'd3, 5'd3}) begin miscompares++; $display("FAIL exact_reach sel=%0d soma=%0d required 3/3", select, soma); end
    @(negedge clk);
    vectors++; if ({dispense, refund, valoramais, select} !== {1'b1, 1'b0, 1'b0, 3'd3}) begin miscompares++; $display("FAIL exact_disp disp=%0b ref=%0b vm=%0b sel=%0d required 1/0/0/3", dispense, refund, valoramais, select); end
    repeat (3) @(negedge clk);
    vectors++; if ({select, dispense} !== {3'd3, 1'b0}) begin miscompares++; $display("FAIL exact_hold sel=%0d disp=%0b required 3/0", select, dispense); end
    @(negedge clk);
    vectors++; if (select !== 3'd0) begin miscompares++; $display("FAIL exact_idle sel=%0d required 0", select); end
  endtask

  task automatic test_sold_out();
    sensores = 3'b001;
    pulse_sel(2'd1);
    vectors++; if ({select, bebida} !== {3'd5, 2'd0}) begin miscompares++; $display("FAIL soldout_msg sel=%0d beb=%0d required 5/0", select, bebida); end
    repeat (3) @(negedge clk);
    vectors++; if (select !== 3'd5) begin miscompares++; $display("FAIL soldout_hold sel=%0d required 5", select); end
    @(negedge clk);
    vectors++; if ({select, bebida} !== {3'd0, 2'd0}) begin miscompares++; $display("FAIL soldout_ret sel=%0d beb=%0d required 0/0", select, bebida); end
    sensores = 3'b000;
  endtask

  task automatic test_invalid_note();
    pulse_sel(2'd1);
    pulse_note(3'd7);
    vectors++; if ({select, cedulaINV, soma} !== {3'd6, 1'b1, 5'd0}) begin miscompares++; $display("FAIL inv_msg sel=%0d inv=%0b soma=%0d required 6/1/0", select, cedulaINV, soma); end
    repeat (3) @(negedge clk);
    vectors++; if ({select, cedulaINV} !== {3'd6, 1'b1}) begin miscompares++; $display("FAIL inv_hold sel=%0d inv=%0b required 6/1", select, cedulaINV); end
    @(negedge clk);
    vectors++; if ({select, cedulaINV, soma} !== {3'd2, 1'b0, 5'd0}) begin miscompares++; $display("FAIL inv_ret sel=%0d inv=%0b soma=%0d required 2/0/0", select, cedulaINV, soma); end
    pulse_cancel();
    vectors++; if ({select, refund} !== {3'd7, 1'b0}) begin miscompares++; $display("FAIL cancel_zero sel=%0d ref=%0b required 7/0", select, refund); end
    repeat (3) @(negedge clk);
    @(negedge clk);
    vectors++; if (select !== 3'd0) begin miscompares++; $display("FAIL cancel_zero_idle sel=%0d required 0", select); end
  endtask

  task automatic test_cancel();
    pulse_sel(2'd3);
    pulse_note(3'd2);
    pulse_note(3'd1);
    vectors++; if (soma !== 5'd3) begin miscompares++; $display("FAIL cancel_credit soma=%0d required 3", soma); end
    pulse_cancel();
    vectors++; if ({select, refund, refund_value, soma, bebida} !== {3'd7, 1'b1, 5'd3, 5'd0, 2'd0}) begin miscompares++; $display("FAIL cancel_refund sel=%0d ref=%0b rv=%0d soma=%0d beb=%0d required 7/1/3/0/0", select, refund, refund_value, soma, bebida); end
    @(negedge clk);
    vectors++; if (refund !== 1'b0) begin miscompares++; $display("FAIL cancel_pulse ref=%0b required 0", refund); end
    repeat (2) @(negedge clk);
    @(negedge clk);
    vectors++; if (select !== 3'd0) begin miscompares++; $display("FAIL cancel_idle sel=%0d required 0", select); end
  endtask

  task automatic test_cancel_priority();
    pulse_sel(2'd3);
    pulse_note(3'd2);
    pulse_note(3'd1);
    @(negedge clk); cancel = 1'b1; note_strobe = 1'b1; note_code = 3'd4;
    @(negedge clk); cancel = 1'b0; note_strobe = 1'b0;
    vectors++; if ({select, refund, refund_value} !== {3'd7, 1'b1, 5'd3}) begin miscompares++; $display("FAIL prio_cancel sel=%0d ref=%0b rv=%0d required 7/1/3", select, refund, refund_value); end
    repeat (3) @(negedge clk);
    @(negedge clk);
    vectors++; if ({select, soma} !== {3'd0, 5'd0}) begin miscompares++; $display("FAIL prio_idle sel=%0d soma=%0d required 0/0", select, soma); end
  endtask

  task automatic test_reset_mid();
    pulse_sel(2'd2);
    pulse_note(3'd2);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    vectors++; if ({refund, soma, select, bebida} !== {1'b0, 5'd0, 3'd0, 2'd0}) begin miscompares++; $display("FAIL reset_mid ref=%0b soma=%0d sel=%0d beb=%0d required 0/0/0/0", refund, soma, select, bebida); end
    reset = 1'b0;
  endtask

  task automatic test_over_limit();
    do_reset();
    pulse_sel(2'd3);
    pulse_note(3'd4);
    pulse_note(3'd4);
    pulse_note(3'd4);
    vectors++; if ({b_select, b_soma} !== {3'd2, 5'd30}) begin miscompares++; $display("FAIL limit_30 sel=%0d soma=%0d required 2/30", b_select, b_soma); end
    pulse_note(3'd2);
    vectors++; if ({b_select, b_cedulaINV, b_soma} !== {3'd6, 1'b1, 5'd30}) begin miscompares++; $display("FAIL limit_reject sel=%0d inv=%0b soma=%0d required 6/1/30", b_select, b_cedulaINV, b_soma); end
    repeat (3) @(negedge clk);
    @(negedge clk);
    vectors++; if ({b_select, b_soma, b_cedulaINV} !== {3'd2, 5'd30, 1'b0}) begin miscompares++; $display("FAIL limit_ret sel=%0d soma=%0d inv=%0b required 2/30/0", b_select, b_soma, b_cedulaINV); end
    pulse_note(3'd1);
    vectors++; if ({b_select, b_soma} !== {3'd3, 5'd31}) begin miscompares++; $display("FAIL limit_31 sel=%0d soma=%0d required 3/31", b_select, b_soma); end
    @(negedge clk);
    vectors++; if ({b_dispense, b_refund} !== {1'b1, 1'b0}) begin miscompares++; $display("FAIL limit_disp disp=%0b ref=%0b required 1/0", b_dispense, b_refund); end
    do_reset();
  endtask

  task automatic test_timeout();
    int seen;
    logic r_cap;
    logic [4:0] rv_cap;
    seen = 0; r_cap = 1'b0; rv_cap = '0;
    pulse_sel(2'd1);
    pulse_note(3'd1);
    vectors++; if ({select, soma} !== {3'd2, 5'd1}) begin miscompares++; $display("FAIL tmo_credit sel=%0d soma=%0d required 2/1", select, soma); end
`ifdef VEND_TIMEOUT_EN
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      @(negedge clk);
      if (select === 3'd7) begin seen = k; r_cap = refund; rv_cap = refund_value; end
    end
    vectors++; if (seen != 20) begin miscompares++; $display("FAIL tmo_cycles cancelled after %0d cycles required 20", seen); end
    vectors++; if ({r_cap, rv_cap} !== {1'b1, 5'd1}) begin miscompares++; $display("FAIL tmo_refund ref=%0b rv=%0d required 1/1", r_cap, rv_cap); end
    repeat (5) @(negedge clk);
`else
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (refund === 1'b1) seen = 1;
    end
    vectors++; if ({select, soma, bebida, seen[0]} !== {3'd2, 5'd1, 2'd1, 1'b0}) begin miscompares++; $display("FAIL tmo_wait sel=%0d soma=%0d beb=%0d refund_seen=%0d required 2/1/1/0", select, soma, bebida, seen); end
    pulse_cancel();
    vectors++; if ({select, refund, refund_value} !== {3'd7, 1'b1, 5'd1}) begin miscompares++; $display("FAIL tmo_cancel sel=%0d ref=%0b rv=%0d required 7/1/1", select, refund, refund_value); end
    repeat (5) @(negedge clk);
`endif
  endtask

  initial begin
    reset = 1'b1; sel_strobe = 1'b0; sel_drink = 2'd0; note_strobe = 1'b0;
    note_code = 3'd0; cancel = 1'b0; sensores = 3'b000;
    test_reset();
    test_purchase_change();
    test_exact_price();
    test_sold_out();
    test_invalid_note();
    test_cancel();
    test_cancel_priority();
    test_reset_mid();
    test_over_limit();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
